// File: rtl/hash_des_sbox_engine.sv
// rtl/hash_des_sbox_engine.sv - handshaked multi-lane DES S5 S-box byte-stream hash engine

// One DES S5 substitution box: row = {sel[5], sel[0]}, column = sel[4:1].
module des_s5_sbox (
    input  logic [5:0] sel,
    output logic [3:0] dout
);
    // Entry e = 16*row + col sits at bit 4*(63-e), so row 0 column 0 is the top nibble.
    localparam logic [255:0] S5_TABLE = {
        64'h2C417AB6_853FD0E9,
        64'hEB2C47D1_50FA3986,
        64'h421BAD78_F9C5630E,
        64'hB8C71E2D_6F09A453
    };

    logic [5:0] entry;

    assign entry = {sel[5], sel[0], sel[4:1]};
    assign dout  = S5_TABLE[{~entry, 2'b00} +: 4];
endmodule

module hash_des_sbox_engine #(
    parameter int          NUM_NIBBLES = 8,
    parameter int          ROUNDS      = 1,
    parameter int          CNT_W       = 64,
    parameter logic [63:0] H_INIT      = 64'hA5C692E8_30FD17B4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [CNT_W-1:0]         counter,
    input  logic                     M_valid,
    output logic                     M_ready,
    input  logic [7:0]               message,
    output logic [4*NUM_NIBBLES-1:0] digest,
    output logic                     hash_ready
);
    localparam int               DW       = 4 * NUM_NIBBLES;
    localparam int               NB       = CNT_W / 8;
    localparam logic [2:0]       RND_LAST = 3'(ROUNDS - 1);
    localparam logic [2:0]       K_LAST   = 3'(NB - 1);
    localparam logic [CNT_W-1:0] ONE_C    = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, ABSORB, FINAL, DONE} state_t;

    state_t           state, state_nx;
    logic [DW-1:0]    h, h_next;
    logic [CNT_W-1:0] rem, len;
    logic [2:0]       rnd, k;
    logic [5:0]       m6_lat, m6_now, m6_use;
    logic [7:0]       cur_byte;
    logic             fire, last_rnd, last_k;

    assign M_ready  = (state == ABSORB) && (rnd == 3'd0);
    assign last_rnd = (rnd == RND_LAST);
    assign last_k   = (k == K_LAST);

    // Pick the byte being absorbed and map it to the 6-bit S-box index; later rounds of a message byte reuse the latched map.
    always_comb begin
        cur_byte = message;
        if (state == FINAL) begin
            cur_byte = len[{k, 3'b000} +: 8];
        end
        m6_now = {cur_byte[3] ^ cur_byte[2], cur_byte[1], cur_byte[0],
                  cur_byte[7], cur_byte[6], cur_byte[5] ^ cur_byte[4]};
        m6_use = ((state == ABSORB) && (rnd != 3'd0)) ? m6_lat : m6_now;
        fire   = (state == FINAL) || ((state == ABSORB) && ((rnd != 3'd0) || M_valid));
    end

    // One round across all lanes: each lane takes its right neighbour XOR its own S-box output.
    for (genvar g = 0; g < NUM_NIBBLES; g++) begin : g_lane
        logic [5:0] s_in;
        logic [3:0] s_out;

        assign s_in = m6_use ^ {2'b00, h[4*g +: 4]};

        des_s5_sbox u_sbox (
            .sel  (s_in),
            .dout (s_out)
        );

        assign h_next[4*g +: 4] = h[4*((g + 1) % NUM_NIBBLES) +: 4] ^ s_out;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode: a byte (or length byte) finishes on its last round.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nx = (counter != '0) ? ABSORB : FINAL;
                end
            end
            ABSORB: begin
                if (fire && last_rnd && (rem == ONE_C)) begin
                    state_nx = FINAL;
                end
            end
            FINAL: begin
                if (last_rnd && last_k) begin
                    state_nx = DONE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: lane state, round/byte counters, length capture and the registered digest.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h          <= '0;
            rem        <= '0;
            len        <= '0;
            rnd        <= '0;
            k          <= '0;
            m6_lat     <= '0;
            digest     <= '0;
            hash_ready <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        h          <= H_INIT[DW-1:0];
                        rem        <= counter;
                        len        <= counter;
                        rnd        <= '0;
                        k          <= '0;
                        hash_ready <= 1'b0;
                    end
                end
                ABSORB: begin
                    if (fire) begin
                        h <= h_next;
                        if (rnd == 3'd0) begin
                            m6_lat <= m6_now;
                        end
                        if (last_rnd) begin
                            rnd <= '0;
                            rem <= rem - ONE_C;
                            k   <= '0;
                        end else begin
                            rnd <= rnd + 3'd1;
                        end
                    end
                end
                FINAL: begin
                    h <= h_next;
                    if (last_rnd) begin
                        rnd <= '0;
                        if (last_k) begin
                            digest     <= h_next;
                            hash_ready <= 1'b1;
                        end else begin
                            k <= k + 3'd1;
                        end
                    end else begin
                        rnd <= rnd + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_hash_des_sbox_engine.sv
// tb/tb_hash_des_sbox_engine.sv - randomized self-checking bench for hash_des_sbox_engine
module tb_hash_des_sbox_engine;
    localparam int          BN  = 8;
    localparam int          BR  = 3;
    localparam int          BCW = 64;
    localparam logic [63:0] BHI = 64'hA5C692E8_30FD17B4;

    typedef logic [7:0] bq_t[$];

    logic clk = 1'b0;
    logic rst_n;

    logic       s_start, s_valid, s_mready, s_hr;
    logic [7:0] s_counter, s_msg, s_digest;

    logic        b_start, b_valid, b_mready, b_hr;
    logic [63:0] b_counter;
    logic [7:0]  b_msg;
    logic [31:0] b_digest;

    int  checks = 0;
    int  errors = 0;
    bq_t msg_q;

    int s5 [4][16] = '{
        '{ 2, 12,  4,  1,  7, 10, 11,  6,  8,  5,  3, 15, 13,  0, 14,  9},
        '{14, 11,  2, 12,  4,  7, 13,  1,  5,  0, 15, 10,  3,  9,  8,  6},
        '{ 4,  2,  1, 11, 10, 13,  7,  8, 15,  9, 12,  5,  6,  3,  0, 14},
        '{11,  8, 12,  7,  1, 14,  2, 13,  6, 15,  0,  9, 10,  4,  5,  3}
    };

    always #5 clk = ~clk;

    hash_des_sbox_engine #(.NUM_NIBBLES(2), .ROUNDS(1), .CNT_W(8), .H_INIT(64'h0)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(s_start), .counter(s_counter),
        .M_valid(s_valid), .M_ready(s_mready), .message(s_msg),
        .digest(s_digest), .hash_ready(s_hr)
    );

    hash_des_sbox_engine #(.NUM_NIBBLES(BN), .ROUNDS(BR), .CNT_W(BCW), .H_INIT(BHI)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .counter(b_counter),
        .M_valid(b_valid), .M_ready(b_mready), .message(b_msg),
        .digest(b_digest), .hash_ready(b_hr)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] model(input int nl, input int rr, input int cw,
                                          input logic [63:0] hi, input bq_t msg, input int n);
        int h [16];
        int nh [16];
        int stream [$];
        int b, m6, x;
        logic [63:0] d;
        for (int i = 0; i < nl; i++) h[i] = int'((hi >> (4 * i)) & 64'hF);
        for (int i = 0; i < n; i++) stream.push_back(int'(msg[i]));
        for (int i = 0; i < cw / 8; i++) stream.push_back(int'((64'(n) >> (8 * i)) & 64'hFF));
        foreach (stream[j]) begin
            b  = stream[j];
            m6 = ((((b >> 3) ^ (b >> 2)) & 1) << 5) | (((b >> 1) & 1) << 4) | ((b & 1) << 3)
               | (((b >> 7) & 1) << 2) | (((b >> 6) & 1) << 1) | (((b >> 5) ^ (b >> 4)) & 1);
            for (int r = 0; r < rr; r++) begin
                for (int i = 0; i < nl; i++) begin
                    x     = m6 ^ h[i];
                    nh[i] = h[(i + 1) % nl] ^ s5[((x >> 5) & 1) * 2 + (x & 1)][(x >> 1) & 15];
                end
                for (int i = 0; i < nl; i++) h[i] = nh[i];
            end
        end
        d = '0;
        for (int i = 0; i < nl; i++) d = d | (64'(h[i]) << (4 * i));
        return d;
    endfunction

    task automatic fill_msg(input int n);
        msg_q.delete();
        for (int i = 0; i < n; i++) msg_q.push_back(8'($urandom));
    endtask

    task automatic run_hash(input int n, input bit poke, input int abort_at);
        logic [63:0] exp, prev;
        bit was_done, accepted;
        int idx, cool, budget, waited;
        exp      = model(BN, BR, BCW, BHI, msg_q, n);
        was_done = b_hr;
        prev     = 64'(b_digest);
        b_counter = 64'(n);
        b_start   = 1'b1;
        b_valid   = 1'($urandom);
        b_msg     = 8'($urandom);
        step();
        b_start = 1'b0;
        check("start_clears_ready", 64'(b_hr), 64'd0);
        if (was_done) check("digest_held", 64'(b_digest), prev);
        idx = 0; cool = 0; budget = 0;
        while ((idx < n || cool != 0) && budget < 1000) begin
            check("m_ready", 64'(b_mready), 64'(idx < n && cool == 0));
            b_valid   = 1'($urandom);
            b_msg     = (idx < n) ? msg_q[idx] : 8'($urandom);
            b_start   = poke ? ($urandom_range(0, 3) == 0) : 1'b0;
            b_counter = {$urandom, $urandom};
            accepted  = b_mready && b_valid;
            step();
            budget++;
            if (accepted) begin
                idx++;
                cool = BR - 1;
            end else if (cool > 0) begin
                cool--;
            end
        end
        check("bytes_consumed", 64'(idx), 64'(n));
        b_valid = 1'b0;
        b_start = 1'b0;
        waited  = 0;
        while (!b_hr && waited < 200) begin
            check("final_no_ready", 64'(b_mready), 64'd0);
            if (abort_at >= 0 && waited == abort_at) begin
                rst_n   = 1'b0;
                b_valid = 1'($urandom);
                step();
                check("abort_digest", 64'(b_digest), 64'd0);
                check("abort_ready", 64'(b_hr), 64'd0);
                check("abort_m_ready", 64'(b_mready), 64'd0);
                rst_n = 1'b1;
                b_valid = 1'b0;
                return;
            end
            b_start = poke ? ($urandom_range(0, 3) == 0) : 1'b0;
            step();
            b_start = 1'b0;
            waited++;
        end
        check("latency", 64'(waited), 64'((BCW / 8) * BR));
        check("digest", 64'(b_digest), exp);
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] d1;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            s_start = 1'($urandom); s_valid = 1'($urandom); s_counter = 8'($urandom); s_msg = 8'($urandom);
            b_start = 1'($urandom); b_valid = 1'($urandom); b_counter = {$urandom, $urandom}; b_msg = 8'($urandom);
            step();
        end
        check("rst_s_digest", 64'(s_digest), 64'd0);
        check("rst_s_ready", 64'(s_hr), 64'd0);
        check("rst_s_m_ready", 64'(s_mready), 64'd0);
        check("rst_b_digest", 64'(b_digest), 64'd0);
        check("rst_b_ready", 64'(b_hr), 64'd0);
        check("rst_b_m_ready", 64'(b_mready), 64'd0);
        s_start = 0; s_valid = 0; b_start = 0; b_valid = 0;
        rst_n = 1'b1;
        step();

        msg_q.delete();
        s_start = 1'b1; s_counter = 8'd0;
        step();
        s_start = 1'b0;
        check("zero_len_not_yet", 64'(s_hr), 64'd0);
        step();
        check("zero_len_ready", 64'(s_hr), 64'd1);
        check("zero_len_digest", 64'(s_digest), 64'h22);
        check("zero_len_model", 64'(s_digest), model(2, 1, 8, 64'h0, msg_q, 0));

        s_start = 1'b1; s_counter = 8'd1;
        step();
        s_start = 1'b0;
        check("one_byte_ready_drop", 64'(s_hr), 64'd0);
        s_valid = 1'b1; s_msg = 8'h00;
        check("one_byte_m_ready", 64'(s_mready), 64'd1);
        step();
        s_valid = 1'b0;
        check("one_byte_m_ready_low", 64'(s_mready), 64'd0);
        check("one_byte_not_yet", 64'(s_hr), 64'd0);
        step();
        check("one_byte_ready", 64'(s_hr), 64'd1);
        check("one_byte_digest", 64'(s_digest), 64'h88);

        fill_msg(5);
        run_hash(5, 1'b0, -1);

        for (int t = 0; t < 6; t++) begin
            int n;
            n = $urandom_range(0, 6);
            fill_msg(n);
            run_hash(n, 1'b1, -1);
        end

        fill_msg(3);
        run_hash(3, 1'b1, 5);
        run_hash(3, 1'b1, -1);

        fill_msg(1);
        run_hash(1, 1'b0, -1);
        d1 = 64'(b_digest);
        run_hash(1, 1'b0, -1);
        check("repeat_digest", 64'(b_digest), d1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
